// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimator read-side blocks.
// Holds the vector and address widths, the field positions inside a vector
// and inside an array address, the default frame size in blocks, the
// dump-reader FSM states, and the layout of one FIFO entry.
package me_pkg;

  localparam int unsigned MV_W    = 14;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned COORD_W = 7;

  // Vector packing: {mv_x, mv_y}, both two's complement.
  localparam int unsigned MV_X_MSB = 13;
  localparam int unsigned MV_X_LSB = 7;
  localparam int unsigned MV_Y_MSB = 6;
  localparam int unsigned MV_Y_LSB = 0;

  // Address packing: {row, col}.
  localparam int unsigned ADDR_ROW_MSB = 13;
  localparam int unsigned ADDR_ROW_LSB = 7;
  localparam int unsigned ADDR_COL_MSB = 6;
  localparam int unsigned ADDR_COL_LSB = 0;

  // 720x576 frame in 16x16 blocks.
  localparam int unsigned DEF_BLK_COLS = 45;
  localparam int unsigned DEF_BLK_ROWS = 36;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_t;

  // Tag carried alongside a read while it is in flight.
  typedef struct packed {
    logic               last;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } dump_tag_t;

  typedef struct packed {
    dump_tag_t       tag;
    logic [MV_W-1:0] mv;
  } dump_entry_t;

  localparam int unsigned ENTRY_W = $bits(dump_entry_t);

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [COORD_W-1:0] row,
                                                input logic [COORD_W-1:0] col);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_ROW_MSB:ADDR_ROW_LSB] = row;
    a[ADDR_COL_MSB:ADDR_COL_LSB] = col;
    return a;
  endfunction

  function automatic logic [MV_X_MSB-MV_X_LSB:0] mv_x_of(input logic [MV_W-1:0] mv);
    return mv[MV_X_MSB:MV_X_LSB];
  endfunction

  function automatic logic [MV_Y_MSB-MV_Y_LSB:0] mv_y_of(input logic [MV_W-1:0] mv);
    return mv[MV_Y_MSB:MV_Y_LSB];
  endfunction

endpackage

// File: rtl/mv_dump_fifo.sv
// Synchronous FIFO of dump entries {last, row, col, mv} with a
// first-word-fall-through head: rd_data shows the oldest entry whenever
// empty is low, and rd_en pops it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push one entry
//   rd_en, rd_data    pop / head entry
//   count, empty      occupancy
module mv_dump_fifo
  import me_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ENTRY_W-1:0]         wr_data,
  input  logic                       rd_en,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_wr, do_rd;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too so the head (and hence m_data) reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/mv_dump_reader.sv
// Motion-vector dump reader. After each frame_end (when dump_en is high) it
// sweeps the motion-vector array's test read port over every block in raster
// order and streams the vectors out on a valid/ready interface, tagged with
// block row/column and a last-vector marker.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   dump_en, frame_end    sweep enable and end-of-frame strobe
//   mv_addr, mv_data      array test read port ({row,col} -> {mv_x,mv_y})
//   m_valid, m_ready      output handshake
//   m_data, m_row, m_col  vector and its block coordinates
//   m_last                marks the final block of the frame
//   busy, done            sweep/drain in progress; end-of-dump pulse
//   overrun, overrun_clr  sticky frame_end-while-busy flag and its clear
module mv_dump_reader
  import me_pkg::*;
#(
  parameter int unsigned BLK_COLS   = DEF_BLK_COLS,
  parameter int unsigned BLK_ROWS   = DEF_BLK_ROWS,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dump_en,
  input  logic        frame_end,
  output logic [13:0] mv_addr,
  input  logic [13:0] mv_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [13:0] m_data,
  output logic [6:0]  m_row,
  output logic [6:0]  m_col,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(BLK_COLS - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(BLK_ROWS - 1);

  dump_state_t        state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
  dump_tag_t          pipe_tag_q [RD_LAT];
  dump_tag_t          pipe_tag_d [RD_LAT];
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rd_data;
  dump_entry_t        head;
  dump_entry_t        wr_entry;
  logic               issue, pop, push, last_pos, start;
  int unsigned        inflight;

  always_comb begin
    last_pos = (row_q == LAST_ROW) && (col_q == LAST_COL);
    start    = (state_q == ST_IDLE) && frame_end && dump_en;

    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 32'(pipe_vld_q[i]);
    end

    // Credit: every read in flight already owns a FIFO slot, so the FIFO
    // can never be asked to accept more than it holds.
    issue = (state_q == ST_SWEEP) && ((32'(fifo_count) + inflight) < FIFO_DEPTH);
    pop   = !fifo_empty && m_ready;
    push  = pipe_vld_q[RD_LAT-1];

    pipe_vld_d[0]        = issue;
    pipe_tag_d[0].last   = last_pos;
    pipe_tag_d[0].row    = row_q;
    pipe_tag_d[0].col    = col_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end

    wr_entry.tag = pipe_tag_q[RD_LAT-1];
    wr_entry.mv  = mv_data;

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_SWEEP: begin
        // Counters stop on the final block so mv_addr keeps that address
        // through drain and idle.
        if (issue) begin
          if (last_pos) begin
            state_d = ST_DRAIN;
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && (inflight == 0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy = (state_q != ST_IDLE) || !fifo_empty;

    overrun_d = overrun_q;
    if (frame_end && dump_en && busy) begin
      overrun_d = 1'b1;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    done_d = pop && head.tag.last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_tag_q[i] <= '0;
      end
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
    end
  end

  mv_dump_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign head    = dump_entry_t'(fifo_rd_data);
  assign mv_addr = mk_addr(row_q, col_q);
  assign m_valid = !fifo_empty;
  assign m_data  = head.mv;
  assign m_row   = head.tag.row;
  assign m_col   = head.tag.col;
  assign m_last  = head.tag.last;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mv_dump_reader.sv
`timescale 1ns/1ps
module tb_mv_dump_reader;

  localparam int unsigned COLS   = 45;
  localparam int unsigned ROWS   = 36;
  localparam int unsigned TOTAL  = COLS * ROWS;
  localparam int unsigned BUDGET = 8000;

  logic clk = 1'b0;
  logic reset;
  logic dump_en;
  logic frame_end;
  logic m_ready;
  logic overrun_clr;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  int unsigned pat_mode   = 0;
  logic [13:0] pat_key    = '0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Contents of the motion-vector array for the current test pattern.
  function automatic logic [13:0] array_word(input logic [13:0] addr);
    case (pat_mode)
      0:       return addr;
      1:       return 14'h203F;
      default: return addr ^ pat_key;
    endcase
  endfunction

  // k-th vector of a frame in raster order.
  function automatic logic [28:0] exp_out(input int unsigned k);
    logic [6:0]  r;
    logic [6:0]  c;
    logic [13:0] a;
    r = 7'(k / COLS);
    c = 7'(k % COLS);
    a = {r, c};
    return {array_word(a), r, c, 1'(k == TOTAL - 1)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;
    localparam int unsigned D = (g == 0) ? 4 : 5;

    logic [13:0] mv_addr, mv_data, m_data;
    logic [6:0]  m_row, m_col;
    logic        m_valid, m_last, busy, done, overrun;
    logic [46:0] outs;
    logic [13:0] rd_pipe [L];
    int unsigned exp_idx  = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    bit          stall_q  = 1'b0;
    logic [28:0] held     = '0;

    mv_dump_reader #(
      .BLK_COLS   (COLS),
      .BLK_ROWS   (ROWS),
      .RD_LAT     (L),
      .FIFO_DEPTH (D)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .dump_en     (dump_en),
      .frame_end   (frame_end),
      .mv_addr     (mv_addr),
      .mv_data     (mv_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_row       (m_row),
      .m_col       (m_col),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
    );

    assign outs = {mv_addr, m_valid, m_data, m_row, m_col, m_last, busy, done, overrun};

    // Array read port with L cycles of latency.
    always @(posedge clk) begin
      rd_pipe[0] <= array_word(mv_addr);
      for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mv_data = rd_pipe[L-1];

    // Scoreboard: every accepted word must be the next raster position.
    always @(negedge clk) begin
      if (!reset) begin
        exp_idx = 0;
        stall_q = 1'b0;
      end else begin
        if (stall_q)
          chk($sformatf("i%0d_hold", g), 64'({m_valid, m_data, m_row, m_col, m_last}),
              64'({1'b1, held}));
        if (m_valid && m_ready) begin
          chk($sformatf("i%0d_word%0d", g, exp_idx), 64'({m_data, m_row, m_col, m_last}),
              64'(exp_out(exp_idx)));
          exp_idx++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk($sformatf("i%0d_count", g), 64'(exp_idx), 64'(TOTAL));
          exp_idx = 0;
        end
        stall_q = m_valid && !m_ready;
        held    = {m_data, m_row, m_col, m_last};
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_frame(output int unsigned t0);
    frame_end = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    frame_end = 1'b0;
    chk("start_addr0", 64'(g_dut[0].mv_addr), 64'd0);
    chk("start_addr1", 64'(g_dut[1].mv_addr), 64'd0);
    chk("start_busy0", 64'(g_dut[0].busy), 64'd1);
    chk("start_busy1", 64'(g_dut[1].busy), 64'd1);
  endtask

  task automatic wait_done();
    int unsigned d0 = g_dut[0].done_cnt;
    int unsigned d1 = g_dut[1].done_cnt;
    int unsigned n  = 0;
    while ((g_dut[0].done_cnt == d0 || g_dut[1].done_cnt == d1) && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen0", 64'(g_dut[0].done_cnt - d0), 64'd1);
    chk("done_seen1", 64'(g_dut[1].done_cnt - d1), 64'd1);
  endtask

  task automatic wait_words(input int unsigned k, input bit need_valid);
    int unsigned n = 0;
    while (!(g_dut[0].exp_idx >= k && (!need_valid || g_dut[0].m_valid)) && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_word", 64'(g_dut[0].exp_idx >= k), 64'd1);
  endtask

  typedef struct packed {
    logic de;
    logic fe;
    logic clr;
    logic exp_busy;
    logic exp_ovr;
  } ctl_vec_t;

  ctl_vec_t    tbl [10];
  int unsigned t0;

  initial begin
    tbl[0] = '{de:1'b0, fe:1'b1, clr:1'b0, exp_busy:1'b0, exp_ovr:1'b0};
    tbl[1] = '{de:1'b1, fe:1'b0, clr:1'b1, exp_busy:1'b0, exp_ovr:1'b0};
    tbl[2] = '{de:1'b1, fe:1'b1, clr:1'b0, exp_busy:1'b1, exp_ovr:1'b0};
    tbl[3] = '{de:1'b1, fe:1'b1, clr:1'b0, exp_busy:1'b1, exp_ovr:1'b1};
    tbl[4] = '{de:1'b1, fe:1'b0, clr:1'b0, exp_busy:1'b1, exp_ovr:1'b1};
    tbl[5] = '{de:1'b1, fe:1'b0, clr:1'b1, exp_busy:1'b1, exp_ovr:1'b0};
    tbl[6] = '{de:1'b1, fe:1'b1, clr:1'b1, exp_busy:1'b1, exp_ovr:1'b0};
    tbl[7] = '{de:1'b0, fe:1'b1, clr:1'b0, exp_busy:1'b1, exp_ovr:1'b0};
    tbl[8] = '{de:1'b1, fe:1'b1, clr:1'b0, exp_busy:1'b1, exp_ovr:1'b1};
    tbl[9] = '{de:1'b0, fe:1'b0, clr:1'b1, exp_busy:1'b1, exp_ovr:1'b0};

    reset = 1'b0; dump_en = 1'b1; frame_end = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_outs0", 64'(g_dut[0].outs), 64'd0);
    chk("rst_outs1", 64'(g_dut[1].outs), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Full frame, {row,col} pattern, consumer always ready.
    pat_mode = 0; rand_ready = 1'b0;
    start_frame(t0);
    wait_done();
    chk("done_lat0", 64'(g_dut[0].done_cyc - t0), 64'(TOTAL + 1 + 2));
    chk("done_lat1", 64'(g_dut[1].done_cyc - t0), 64'(TOTAL + 3 + 2));

    // Random data key, random backpressure.
    pat_mode = 2; pat_key = 14'($urandom); rand_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    start_frame(t0);
    wait_done();

    // Control table: dump_en gating, overrun set/clear priority.
    pat_key = 14'($urandom);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      dump_en = tbl[i].de; frame_end = tbl[i].fe; overrun_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_busy0", i), 64'(g_dut[0].busy), 64'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_busy1", i), 64'(g_dut[1].busy), 64'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_ovr0", i), 64'(g_dut[0].overrun), 64'(tbl[i].exp_ovr));
      chk($sformatf("tbl%0d_ovr1", i), 64'(g_dut[1].overrun), 64'(tbl[i].exp_ovr));
    end
    dump_en = 1'b1; frame_end = 1'b0; overrun_clr = 1'b0;
    wait_done();

    // Second strobe at word 100: flagged, sweep unaffected.
    pat_mode = 0; rand_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    start_frame(t0);
    wait_words(100, 1'b0);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    chk("ovr_w100_0", 64'(g_dut[0].overrun), 64'd1);
    chk("ovr_w100_1", 64'(g_dut[1].overrun), 64'd1);
    wait_done();
    chk("ovr_lat0", 64'(g_dut[0].done_cyc - t0), 64'(TOTAL + 1 + 2));
    chk("ovr_lat1", 64'(g_dut[1].done_cyc - t0), 64'(TOTAL + 3 + 2));
    repeat (4) @(posedge clk); #1;
    chk("no_resweep0", 64'(g_dut[0].busy), 64'd0);
    chk("no_resweep1", 64'(g_dut[1].busy), 64'd0);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_clr0", 64'(g_dut[0].overrun), 64'd0);
    chk("ovr_clr1", 64'(g_dut[1].overrun), 64'd0);

    // dump_en low: strobe ignored, address held on the final block.
    dump_en = 1'b0; frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("dis_busy0", 64'(g_dut[0].busy), 64'd0);
    chk("dis_busy1", 64'(g_dut[1].busy), 64'd0);
    chk("dis_ovr0", 64'(g_dut[0].overrun), 64'd0);
    chk("dis_addr0", 64'(g_dut[0].mv_addr), 64'({7'(ROWS - 1), 7'(COLS - 1)}));
    chk("dis_addr1", 64'(g_dut[1].mv_addr), 64'({7'(ROWS - 1), 7'(COLS - 1)}));
    dump_en = 1'b1;

    // Extreme vector values pass through unchanged.
    pat_mode = 1; rand_ready = 1'b1;
    start_frame(t0);
    wait_done();

    // Reset mid-sweep with a word pending, then a clean restart.
    pat_mode = 2; pat_key = 14'($urandom);
    repeat (2) @(posedge clk); #1;
    start_frame(t0);
    wait_words(500, 1'b1);
    chk("pre_rst_valid", 64'(g_dut[0].m_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs0", 64'(g_dut[0].outs), 64'd0);
    chk("mid_rst_outs1", 64'(g_dut[1].outs), 64'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    pat_mode = 0; rand_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    start_frame(t0);
    wait_done();
    chk("rst_lat0", 64'(g_dut[0].done_cyc - t0), 64'(TOTAL + 1 + 2));
    chk("rst_lat1", 64'(g_dut[1].done_cyc - t0), 64'(TOTAL + 3 + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_dump_reader.md
# mv_dump_reader

Read-side companion of the motion-vector array in the 3DRS estimator. After each frame, the block sweeps the array's test read port (`testAddr` -> `testMV`) across every block position and streams the vectors out on a valid/ready interface. Output goes to the host / DMA side, in raster order, with block coordinates and a last-vector marker. It lives beside the estimator top and is driven by its `frameendout` strobe.

## Interface
Parameters:
- `BLK_COLS`, 45: blocks per row (720/16); legal range 1..128.
- `BLK_ROWS`, 36: block rows per frame (576/16); legal range 1..128.
- `RD_LAT`, 1: cycles from `mv_addr` to valid `mv_data`; legal range 1..3.
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ `RD_LAT`+2.

Ports:
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `dump_en`, in, 1: when low, `frame_end` is ignored; a sweep already running completes.
- `frame_end`, in, 1: single-cycle strobe from the estimator (`frameendout`).
- `mv_addr`, out, 14: array read address = {row[6:0], col[6:0]}; drives `testAddr`.
- `mv_data`, in, 14: array read data (`testMV`) = {mv_x[13:7], mv_y[6:0]}, two's complement.
- `m_valid`, out, 1: output word valid.
- `m_ready`, in, 1: consumer accepts the word.
- `m_data`, out, 14: vector, same packing as `mv_data`.
- `m_row`, out, 7: block row of `m_data`.
- `m_col`, out, 7: block column of `m_data`.
- `m_last`, out, 1: high with the final vector (`BLK_ROWS`-1, `BLK_COLS`-1).
- `busy`, out, 1: sweep in progress, or FIFO not empty.
- `done`, out, 1: one-cycle pulse, the cycle after the `m_last` word is accepted.
- `overrun`, out, 1: sticky; set when `frame_end` arrives while `busy` and `dump_en` is high.
- `overrun_clr`, in, 1: synchronous clear of `overrun`; takes priority over a set in the same cycle.

## Operation
- FSM has three states: IDLE, SWEEP, DRAIN.
  - IDLE → SWEEP on `frame_end & dump_en`. Row and column counters are zeroed.
  - SWEEP → DRAIN in the cycle after the last address issues.
  - DRAIN → IDLE when the FIFO is empty and no reads are in flight; `done` pulses on this transition.
- Address issue, in SWEEP only: issue when `fifo_count + inflight < FIFO_DEPTH`.
  - On issue, `mv_addr` updates to the next {row, col}.
  - The column counter wraps at `BLK_COLS`-1 to 0 and increments the row.
- Read tracking: a shift pipeline `RD_LAT` deep carries {issue, row, col, last}. On its exit, `mv_data` is written to the FIFO together with the tag.
- FIFO output: head entry drives `m_*`; pop when `m_valid & m_ready`. The `m_*` outputs are held stable while `m_valid & !m_ready`.
- `frame_end` while `busy`: the strobe is ignored and `overrun` is set; the current sweep is not disturbed.
- `mv_addr` holds its last value while IDLE.
- Reset, including mid-sweep, clears everything below. The next frame starts a fresh sweep.
  - Outputs: `mv_addr`=0, `m_valid`=0, `m_data`=0, `m_row`=0, `m_col`=0, `m_last`=0, `busy`=0, `done`=0, `overrun`=0.
  - Internal state: FIFO, in-flight pipeline and counters.

## Timing
- `frame_end` at cycle T: SWEEP at T+1, first address {0,0} on `mv_addr` in T+1, `busy` high from T+1.
- Address issued in cycle t: `mv_data` is sampled at the end of cycle t+`RD_LAT`, and the word appears on `m_valid` at t+`RD_LAT`+1.
- With `m_ready` held high and `FIFO_DEPTH` ≥ `RD_LAT`+2: one vector per cycle. A full frame takes `BLK_ROWS`·`BLK_COLS` + `RD_LAT` + 2 cycles from T to `done`.
- Backpressure: address issue stalls within one cycle of the FIFO credit running out. No word is ever lost or duplicated.

## Structure
- Shared package `me_pkg` holds:
  - widths `MV_W`=14, `ADDR_W`=14, `COORD_W`=7;
  - field slices for mv_x/mv_y and row/col;
  - default frame block dimensions;
  - FSM state enum.
- Sub-module `mv_dump_fifo`: synchronous FIFO of {last, row, col, mv}, with count output and first-word-fall-through head.

## Test plan
- Fill a behavioral array model with `mv_data` = {row, col} pattern (`RD_LAT`=1), `m_ready`=1, pulse `frame_end`.
  - Expect 1620 words in raster order.
  - First word is row 0 / col 0; the last has row 35 / col 44 with `m_last`=1.
  - `done` arrives exactly 1623 cycles after the strobe.
- Random `m_ready` (50% duty): same 1620 words with no gaps or duplicates, and `m_*` stable during stalls. Repeat with `RD_LAT`=3, `FIFO_DEPTH`=5.
- Second `frame_end` at word 100: `overrun`=1 and the sweep completes unchanged. `overrun_clr` drops `overrun`, and a simultaneous set+clear leaves 0.
- `dump_en`=0 with `frame_end`: stays IDLE, `busy`=0, `overrun`=0.
- Assert `reset` low at word 500 with `m_valid` high: all outputs reach their reset values immediately. After release, the next `frame_end` restarts at {0,0}.
- Array model holding mv_x=-64 and mv_y=63 (14'h203F): `m_data`=14'h203F, unchanged.
